// File: rtl/spi_read_arbiter.sv
// rtl/spi_read_arbiter.sv - round-robin arbiter sharing one SPI flash read port among NUM_REQ requesters
module spi_read_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
    output logic [NUM_REQ-1:0]        o_rd_done,
    output logic [NUM_REQ-1:0]        o_rd_err,
    output logic [7:0]                o_rd_data,
    output logic [NUM_REQ-1:0]        o_busy,
    output logic                      o_spi_start_read,
    output logic [ADDR_W-1:0]         o_spi_addr,
    input  logic                      i_spi_data_ready,
    input  logic [7:0]                i_spi_data
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic [PTR_W-1:0]     r_owner;
    logic [PTR_W-1:0]     w_owner_next;
    logic [PTR_W-1:0]     w_winner;
    logic [PTR_W-1:0]     w_idx;
    logic                 w_found;
    logic                 w_timeout;
    logic [NUM_REQ-1:0]   r_pend;
    logic [NUM_REQ-1:0]   w_pend_next;
    logic [NUM_REQ-1:0]   w_grant_mask;
    logic [NUM_REQ-1:0]   w_busy_next;
    logic [ADDR_W-1:0]    r_addr_q [NUM_REQ];
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_REQ-1:0]   r_rd_done;
    logic [NUM_REQ-1:0]   r_rd_err;
    logic [7:0]           r_rd_data;
    logic [NUM_REQ-1:0]   r_busy;
    logic                 r_spi_start_read;
    logic [ADDR_W-1:0]    r_spi_addr;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    // First pending requester at or above rr_ptr, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && r_pend[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT:  if (i_spi_data_ready || w_timeout) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // busy is registered, so it is computed from the next-cycle pend/state/owner.
    always_comb begin
        w_grant_mask = '0;
        w_owner_next = r_owner;
        if (r_state == S_IDLE && w_found) begin
            w_grant_mask = NUM_REQ'(1) << w_winner;
            w_owner_next = w_winner;
        end
        w_pend_next = (r_pend & ~w_grant_mask) | i_req;
        w_busy_next = w_pend_next;
        if (w_state_next != S_IDLE) begin
            w_busy_next = w_pend_next | (NUM_REQ'(1) << w_owner_next);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state          <= S_IDLE;
            r_rr_ptr         <= '0;
            r_owner          <= '0;
            r_pend           <= '0;
            r_cnt            <= '0;
            r_rd_done        <= '0;
            r_rd_err         <= '0;
            r_rd_data        <= 8'h00;
            r_busy           <= '0;
            r_spi_start_read <= 1'b0;
            r_spi_addr       <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_addr_q[i] <= '0;
            end
        end else begin
            r_state          <= w_state_next;
            r_owner          <= w_owner_next;
            r_pend           <= w_pend_next;
            r_busy           <= w_busy_next;
            r_spi_start_read <= 1'b0;
            r_rd_done        <= '0;
            r_rd_err         <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i_req[i]) begin
                    r_addr_q[i] <= i_req_addr[i*ADDR_W +: ADDR_W];
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_spi_addr       <= r_addr_q[w_winner];
                        r_rr_ptr         <= (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
                        r_spi_start_read <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    if (i_spi_data_ready) begin
                        r_rd_data <= i_spi_data;
                        r_rd_done <= NUM_REQ'(1) << r_owner;
                    end else if (w_timeout) begin
                        r_rd_data <= 8'h00;
                        r_rd_err  <= NUM_REQ'(1) << r_owner;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rd_done        = r_rd_done;
    assign o_rd_err         = r_rd_err;
    assign o_rd_data        = r_rd_data;
    assign o_busy           = r_busy;
    assign o_spi_start_read = r_spi_start_read;
    assign o_spi_addr       = r_spi_addr;
endmodule

// File: tb/tb_spi_read_arbiter.sv
// tb/tb_spi_read_arbiter.sv - directed self-checking bench for spi_read_arbiter
module tb_spi_read_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [95:0] req_addr;
    logic [3:0]  rd_done;
    logic [3:0]  rd_err;
    logic [7:0]  rd_data;
    logic [3:0]  busy;
    logic        start;
    logic [23:0] spi_addr;
    logic        ready;
    logic [7:0]  sdata;

    int checks   = 0;
    int failures = 0;

    spi_read_arbiter #(.NUM_REQ(4), .ADDR_W(24), .TIMEOUT(15)) dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_req            (req),
        .i_req_addr       (req_addr),
        .o_rd_done        (rd_done),
        .o_rd_err         (rd_err),
        .o_rd_data        (rd_data),
        .o_busy           (busy),
        .o_spi_start_read (start),
        .o_spi_addr       (spi_addr),
        .i_spi_data_ready (ready),
        .i_spi_data       (sdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; req = '0; req_addr = '0; ready = 1'b0; sdata = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic pulse(input logic [3:0] m, input logic [95:0] a);
        req = m; req_addr = a;
        step();
        req = '0;
    endtask

    task automatic wait_start(input int max_cycles);
        int n = 0;
        while (start !== 1'b1 && n < max_cycles) begin
            step();
            n++;
        end
    endtask

    // Called in the start cycle; answers two cycles later, returns in the following IDLE cycle.
    task automatic serve(input logic [7:0] d, output logic [23:0] a,
                         output logic [3:0] done, output logic [7:0] data);
        a = spi_addr;
        step();
        step();
        ready = 1'b1; sdata = d;
        step();
        done = rd_done; data = rd_data;
        ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; req_addr = '0; ready = 1'b0; sdata = '0;
        step();
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", start); end
        checks++; if (spi_addr !== 24'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", spi_addr); end
        checks++; if (rd_done !== 4'b0 || rd_err !== 4'b0) begin failures++; $display("FAIL reset_strobes done=%b err=%b exp=0", rd_done, rd_err); end
        checks++; if (rd_data !== 8'h00 || busy !== 4'b0) begin failures++; $display("FAIL reset_data_busy data=%h busy=%b exp=0", rd_data, busy); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [23:0] a;
        apply_reset();
        req = 4'b0100; req_addr = '0; req_addr[2*24 +: 24] = 24'h012345;
        step();
        req = '0;
        checks++; if (busy !== 4'b0100 || start !== 1'b0) begin failures++; $display("FAIL single_t1 busy=%b start=%b exp=0100/0", busy, start); end
        step();
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", start); end
        a = spi_addr;
        checks++; if (a !== 24'h012345) begin failures++; $display("FAIL single_addr got=%h exp=012345", a); end
        step(); step(); step();
        checks++; if (busy !== 4'b0100 || rd_done !== 4'b0) begin failures++; $display("FAIL single_wait busy=%b done=%b exp=0100/0000", busy, rd_done); end
        step();
        ready = 1'b1; sdata = 8'hA5;
        step();
        ready = 1'b0;
        checks++; if (rd_done !== 4'b0100) begin failures++; $display("FAIL single_done got=%b exp=0100", rd_done); end
        checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", rd_data); end
        checks++; if (busy !== 4'b0100 || spi_addr !== 24'h012345) begin failures++; $display("FAIL single_busy_done busy=%b addr=%h exp=0100/012345", busy, spi_addr); end
        step();
        checks++; if (rd_done !== 4'b0 || busy !== 4'b0 || rd_data !== 8'hA5) begin failures++; $display("FAIL single_after done=%b busy=%b data=%h exp=0000/0000/a5", rd_done, busy, rd_data); end
    endtask

    task automatic test_simultaneous();
        logic [23:0] a; logic [3:0] d; logic [7:0] x;
        apply_reset();
        pulse(4'b1111, {24'h40, 24'h30, 24'h20, 24'h10});
        checks++; if (busy !== 4'b1111) begin failures++; $display("FAIL simul_busy got=%b exp=1111", busy); end
        for (int k = 0; k < 4; k++) begin
            wait_start(10);
            checks++; if (start !== 1'b1) begin failures++; $display("FAIL simul_start%0d got=%b exp=1", k, start); end
            serve(8'(8'h60 + k), a, d, x);
            checks++; if (a !== 24'((k + 1) * 16)) begin failures++; $display("FAIL simul_addr%0d got=%h exp=%h", k, a, 24'((k + 1) * 16)); end
            checks++; if (d !== 4'(1 << k) || x !== 8'(8'h60 + k)) begin failures++; $display("FAIL simul_done%0d got=%b/%h exp=%b/%h", k, d, x, 4'(1 << k), 8'(8'h60 + k)); end
        end
    endtask

    task automatic test_rr_wrap();
        logic [23:0] a; logic [3:0] d; logic [7:0] x;
        logic [3:0] exp_done [5] = '{4'b0001, 4'b0010, 4'b0001, 4'b1000, 4'b0001};
        logic [23:0] exp_addr [5] = '{24'h111, 24'h222, 24'h333, 24'h444, 24'h555};
        for (int k = 0; k < 5; k++) begin
            if (k == 0) pulse(4'b0011, {24'h0, 24'h0, 24'h222, 24'h111});
            if (k == 2) pulse(4'b0001, {24'h0, 24'h0, 24'h0, 24'h333});
            if (k == 3) pulse(4'b1001, {24'h444, 24'h0, 24'h0, 24'h555});
            wait_start(10);
            checks++; if (start !== 1'b1) begin failures++; $display("FAIL rr_start%0d got=%b exp=1", k, start); end
            serve(8'h33, a, d, x);
            checks++; if (d !== exp_done[k] || a !== exp_addr[k]) begin failures++; $display("FAIL rr_order%0d got=%b/%h exp=%b/%h", k, d, a, exp_done[k], exp_addr[k]); end
        end
    endtask

    task automatic test_merge();
        logic [23:0] a; logic [3:0] d; logic [7:0] x; int n;
        apply_reset();
        pulse(4'b0001, {72'h0, 24'h500});
        wait_start(10);
        step();
        pulse(4'b0010, {48'h0, 24'h100, 24'h0});
        pulse(4'b0010, {48'h0, 24'h200, 24'h0});
        ready = 1'b1; sdata = 8'h11;
        step();
        ready = 1'b0;
        checks++; if (rd_done !== 4'b0001) begin failures++; $display("FAIL merge_first got=%b exp=0001", rd_done); end
        step();
        checks++; if (busy !== 4'b0010) begin failures++; $display("FAIL merge_busy got=%b exp=0010", busy); end
        wait_start(10);
        serve(8'h22, a, d, x);
        checks++; if (a !== 24'h200 || d !== 4'b0010) begin failures++; $display("FAIL merge_read got=%h/%b exp=000200/0010", a, d); end
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (start === 1'b1) n++;
            step();
        end
        checks++; if (n != 0 || busy !== 4'b0) begin failures++; $display("FAIL merge_single starts=%0d busy=%b exp=0/0000", n, busy); end
    endtask

    task automatic test_timeout();
        logic [23:0] a; logic [3:0] d; logic [7:0] x;
        apply_reset();
        pulse(4'b0110, {24'h0, 24'h777, 24'hABC, 24'h0});
        wait_start(10);
        checks++; if (start !== 1'b1 || spi_addr !== 24'hABC) begin failures++; $display("FAIL to_start got=%b/%h exp=1/000abc", start, spi_addr); end
        for (int i = 0; i < 16; i++) step();
        checks++; if (rd_err !== 4'b0) begin failures++; $display("FAIL to_early got=%b exp=0000", rd_err); end
        step();
        checks++; if (rd_err !== 4'b0010 || rd_data !== 8'h00 || rd_done !== 4'b0) begin failures++; $display("FAIL to_err err=%b data=%h done=%b exp=0010/00/0000", rd_err, rd_data, rd_done); end
        step();
        ready = 1'b1; sdata = 8'h77;
        step();
        ready = 1'b0;
        checks++; if (start !== 1'b1 || spi_addr !== 24'h777) begin failures++; $display("FAIL to_next got=%b/%h exp=1/000777", start, spi_addr); end
        checks++; if (rd_done !== 4'b0 || rd_err !== 4'b0 || rd_data !== 8'h00) begin failures++; $display("FAIL to_late_ready done=%b err=%b data=%h exp=0000/0000/00", rd_done, rd_err, rd_data); end
        serve(8'h5A, a, d, x);
        checks++; if (d !== 4'b0100 || x !== 8'h5A) begin failures++; $display("FAIL to_recover got=%b/%h exp=0100/5a", d, x); end
    endtask

    task automatic test_reset_mid();
        logic [23:0] a; logic [3:0] d; logic [7:0] x; int n;
        apply_reset();
        pulse(4'b0001, {72'h0, 24'h333});
        wait_start(10);
        serve(8'hC3, a, d, x);
        pulse(4'b0001, {72'h0, 24'h333});
        wait_start(10);
        step();
        pulse(4'b1010, {24'h999, 24'h0, 24'h888, 24'h0});
        checks++; if (busy !== 4'b1011 || rd_data !== 8'hC3) begin failures++; $display("FAIL mid_pre busy=%b data=%h exp=1011/c3", busy, rd_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 4'b0 || rd_data !== 8'h00 || spi_addr !== 24'h0) begin failures++; $display("FAIL mid_async busy=%b data=%h addr=%h exp=0", busy, rd_data, spi_addr); end
        step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (start === 1'b1) n++;
        end
        checks++; if (n != 0 || busy !== 4'b0) begin failures++; $display("FAIL mid_quiet starts=%0d busy=%b exp=0/0000", n, busy); end
        pulse(4'b1000, {24'hAAA, 72'h0});
        wait_start(10);
        checks++; if (start !== 1'b1 || spi_addr !== 24'hAAA) begin failures++; $display("FAIL mid_newreq got=%b/%h exp=1/000aaa", start, spi_addr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_rr_wrap();
        test_merge();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
